// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style main controller.
// The state register advances on the rising clock edge; every control output is
// decoded combinationally from the current state, the memory-ready and zero
// flags, and the instruction fields, and is forced low while reset is high.
module multi_cycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       reg_write_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [3:0] state_o,
  output logic       instr_done_o,
  output logic       illegal_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_JR       = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t state_reg;

  logic is_rtype, is_jr, is_beq, is_addi, is_slti, is_lw, is_sw, is_j, is_jal;

  // Opcode classification; the instruction register is stable for the whole instruction.
  always_comb begin
    is_rtype = (instr_op_i == OP_RTYPE);
    is_jr    = is_rtype && (funct_i == FN_JR);
    is_beq   = (instr_op_i == OP_BEQ);
    is_addi  = (instr_op_i == OP_ADDI);
    is_slti  = (instr_op_i == OP_SLTI);
    is_lw    = (instr_op_i == OP_LW);
    is_sw    = (instr_op_i == OP_SW);
    is_j     = (instr_op_i == OP_J);
    is_jal   = (instr_op_i == OP_JAL);
  end

  // State sequencer: memory states wait for mem_ready_i, all others advance unconditionally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_FETCH;
    end else begin
      case (state_reg)
        S_FETCH:    if (mem_ready_i) state_reg <= S_DECODE;
        S_DECODE: begin
          if (is_lw || is_sw)            state_reg <= S_MEM_ADDR;
          else if (is_jr)                state_reg <= S_JR;
          else if (is_rtype)             state_reg <= S_R_EXEC;
          else if (is_beq)               state_reg <= S_BRANCH;
          else if (is_j || is_jal)       state_reg <= S_JUMP;
          else if (is_addi || is_slti)   state_reg <= S_I_EXEC;
          else                           state_reg <= S_FETCH;
        end
        S_MEM_ADDR: state_reg <= is_sw ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (mem_ready_i) state_reg <= S_MEM_WB;
        S_MEM_WB:   state_reg <= S_FETCH;
        S_MEM_WR:   if (mem_ready_i) state_reg <= S_FETCH;
        S_R_EXEC:   state_reg <= S_R_WB;
        S_R_WB:     state_reg <= S_FETCH;
        S_BRANCH:   state_reg <= S_FETCH;
        S_JUMP:     state_reg <= S_FETCH;
        S_JR:       state_reg <= S_FETCH;
        S_I_EXEC:   state_reg <= S_I_WB;
        S_I_WB:     state_reg <= S_FETCH;
        default:    state_reg <= S_FETCH;
      endcase
    end
  end

  // Output decode; everything defaults low and reset suppresses all strobes in the same cycle.
  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    iord_o       = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = 2'b00;
    reg_write_o  = 1'b0;
    reg_dst_o    = 2'b00;
    mem_to_reg_o = 2'b00;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 3'b000;
    state_o      = 4'd0;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;
    if (!rst_i) begin
      state_o = state_reg;
      case (state_reg)
        S_FETCH: begin
          mem_req_o   = 1'b1;
          alu_src_b_o = 2'b01;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        S_DECODE: begin
          alu_src_b_o = 2'b11;
          if (!(is_rtype || is_beq || is_addi || is_slti ||
                is_lw || is_sw || is_j || is_jal)) begin
            illegal_o    = 1'b1;
            instr_done_o = 1'b1;
          end
        end
        S_MEM_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
        end
        S_MEM_RD: begin
          mem_req_o = 1'b1;
          iord_o    = 1'b1;
        end
        S_MEM_WB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 2'b01;
          instr_done_o = 1'b1;
        end
        S_MEM_WR: begin
          mem_req_o    = 1'b1;
          mem_we_o     = 1'b1;
          iord_o       = 1'b1;
          instr_done_o = mem_ready_i;
        end
        S_R_EXEC: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = 3'b010;
        end
        S_R_WB: begin
          reg_write_o  = 1'b1;
          reg_dst_o    = 2'b01;
          instr_done_o = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o  = 1'b1;
          alu_op_o     = 3'b001;
          pc_src_o     = 2'b01;
          pc_write_o   = zero_i;
          instr_done_o = 1'b1;
        end
        S_JUMP: begin
          pc_write_o   = 1'b1;
          pc_src_o     = 2'b10;
          instr_done_o = 1'b1;
          if (is_jal) begin
            reg_write_o  = 1'b1;
            reg_dst_o    = 2'b10;
            mem_to_reg_o = 2'b10;
          end
        end
        S_JR: begin
          pc_write_o   = 1'b1;
          pc_src_o     = 2'b11;
          instr_done_o = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          alu_op_o    = is_slti ? 3'b100 : 3'b000;
        end
        S_I_WB: begin
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized bench for multi_cycle_ctrl. A per-instruction reference model turns
// an instruction class plus wait counts into the expected cycle-by-cycle trace of
// all control outputs; each cycle the whole output set is compared at the falling edge.
module tb_multi_cycle_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] instr_op_i;
  logic [5:0] funct_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o;
  logic [1:0] pc_src_o;
  logic       reg_write_o;
  logic [1:0] reg_dst_o, mem_to_reg_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;
  logic       instr_done_o, illegal_o;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic       done;
    logic       illegal;
  } outs_t;

  typedef struct {
    outs_t o;
    logic  ready;
    logic  rst;
  } step_t;

  step_t plan[$];

  always #5 clk_i = ~clk_i;

  multi_cycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .funct_i(funct_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .iord_o(iord_o), .ir_write_o(ir_write_o),
    .pc_write_o(pc_write_o), .pc_src_o(pc_src_o), .reg_write_o(reg_write_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .state_o(state_o),
    .instr_done_o(instr_done_o), .illegal_o(illegal_o)
  );

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h required=%h", tag, got, exp);
    end
  endtask

  function automatic outs_t st(input logic [3:0] code);
    outs_t o;
    o = '0;
    o.state = code;
    return o;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input outs_t o, input logic rdy);
    step_t s;
    s.o = o;
    s.ready = rdy;
    s.rst = 1'b0;
    plan.push_back(s);
  endtask

  // Reference trace for one instruction: fetch (with fw wait cycles), decode,
  // then the class-specific tail; mw wait cycles apply to the data access.
  task automatic build_plan(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int mw);
    outs_t o;
    bit rt, jr, beq, addi, slti, lw, sw, j, jal;
    rt = (op == 6'b000000); jr = rt && (fn == 6'b001000);
    beq = (op == 6'b000100); addi = (op == 6'b001000); slti = (op == 6'b001010);
    lw = (op == 6'b100011); sw = (op == 6'b101011);
    j = (op == 6'b000010); jal = (op == 6'b000011);
    plan.delete();
    o = st(4'd0); o.mem_req = 1; o.alu_src_b = 2'b01;
    for (int i = 0; i < fw; i++) add(o, 1'b0);
    o.ir_write = 1; o.pc_write = 1;
    add(o, 1'b1);
    o = st(4'd1); o.alu_src_b = 2'b11;
    if (!(rt || beq || addi || slti || lw || sw || j || jal)) begin
      o.illegal = 1; o.done = 1;
      add(o, rnd_bit());
    end else begin
      add(o, rnd_bit());
      if (lw || sw) begin
        o = st(4'd2); o.alu_src_a = 1; o.alu_src_b = 2'b10;
        add(o, rnd_bit());
        o = st(lw ? 4'd3 : 4'd5); o.mem_req = 1; o.iord = 1; o.mem_we = sw;
        for (int i = 0; i < mw; i++) add(o, 1'b0);
        if (sw) o.done = 1;
        add(o, 1'b1);
        if (lw) begin
          o = st(4'd4); o.reg_write = 1; o.mem_to_reg = 2'b01; o.done = 1;
          add(o, rnd_bit());
        end
      end else if (jr) begin
        o = st(4'd10); o.pc_write = 1; o.pc_src = 2'b11; o.done = 1;
        add(o, rnd_bit());
      end else if (rt) begin
        o = st(4'd6); o.alu_src_a = 1; o.alu_op = 3'b010;
        add(o, rnd_bit());
        o = st(4'd7); o.reg_write = 1; o.reg_dst = 2'b01; o.done = 1;
        add(o, rnd_bit());
      end else if (beq) begin
        o = st(4'd8); o.alu_src_a = 1; o.alu_op = 3'b001; o.pc_src = 2'b01;
        o.pc_write = z; o.done = 1;
        add(o, rnd_bit());
      end else if (j || jal) begin
        o = st(4'd9); o.pc_write = 1; o.pc_src = 2'b10; o.done = 1;
        if (jal) begin o.reg_write = 1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; end
        add(o, rnd_bit());
      end else begin
        o = st(4'd11); o.alu_src_a = 1; o.alu_src_b = 2'b10;
        o.alu_op = slti ? 3'b100 : 3'b000;
        add(o, rnd_bit());
        o = st(4'd12); o.reg_write = 1; o.done = 1;
        add(o, rnd_bit());
      end
    end
  endtask

  // Drive one instruction through the DUT; rst_at >= 0 replaces that cycle
  // (and the rest of the instruction) with a reset cycle expecting all-zero outputs.
  task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input int fw, input int mw, input int rst_at);
    step_t s;
    outs_t got;
    int n;
    build_plan(op, fn, z, fw, mw);
    if (rst_at >= 0 && rst_at < plan.size()) begin
      while (plan.size() > rst_at) void'(plan.pop_back());
      s.o = '0; s.ready = rnd_bit(); s.rst = 1'b1;
      plan.push_back(s);
    end
    n = plan.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      if (i == 0) begin
        instr_op_i = op; funct_i = fn; zero_i = z;
      end
      mem_ready_i = plan[i].ready;
      rst_i = plan[i].rst;
      @(negedge clk_i);
      got = {mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
             reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
             alu_op_o, state_o, instr_done_o, illegal_o};
      check($sformatf("%s_c%0d", name, i), got, plan[i].o);
    end
    $display("[TB] %s op=%b funct=%b zero=%b waits=%0d/%0d cycles=%0d rst_at=%0d",
             name, op, fn, z, fw, mw, n, rst_at);
  endtask

  initial begin
    logic [5:0] ops [10];
    logic [5:0] op, fn;
    int fw, mw, ra;
    ops = '{6'b000000, 6'b000100, 6'b001000, 6'b001010, 6'b100011,
            6'b101011, 6'b000010, 6'b000011, 6'b000000, 6'b111111};
    rst_i = 1'b1; instr_op_i = '0; funct_i = '0; zero_i = 1'b0; mem_ready_i = 1'b1;
    // reset held: all outputs low regardless of inputs
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      mem_ready_i = rnd_bit(); zero_i = rnd_bit();
      @(negedge clk_i);
      check("reset_outs", {mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
            reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o,
            state_o, instr_done_o, illegal_o}, 24'h0);
    end

    run("add",     6'b000000, 6'b100000, 1'b0, 0, 0, -1);
    run("lw_w3",   6'b100011, 6'b000000, 1'b0, 0, 3, -1);
    run("beq_z1",  6'b000100, 6'b000000, 1'b1, 0, 0, -1);
    run("beq_z0",  6'b000100, 6'b000000, 1'b0, 0, 0, -1);
    run("jal",     6'b000011, 6'b000000, 1'b0, 0, 0, -1);
    run("jr",      6'b000000, 6'b001000, 1'b0, 0, 0, -1);
    run("j",       6'b000010, 6'b000000, 1'b0, 1, 0, -1);
    run("illegal", 6'b111111, 6'b000000, 1'b0, 0, 0, -1);
    run("addi",    6'b001000, 6'b000000, 1'b0, 2, 0, -1);
    run("slti",    6'b001010, 6'b000000, 1'b0, 0, 0, -1);
    run("sw",      6'b101011, 6'b000000, 1'b0, 0, 1, -1);
    run("sw_rst",  6'b101011, 6'b000000, 1'b0, 0, 2, 4);
    run("after_rst", 6'b000000, 6'b100010, 1'b0, 0, 0, -1);

    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 9)];
      fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 9)) : -1;
      run($sformatf("rnd%0d", k), op, fn, rnd_bit(), fw, mw, ra);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Ports SHALL be as follows:
- clk_i        input   1  clock; all state changes on rising edge.
- rst_i        input   1  synchronous active-high reset.
- instr_op_i   input   6  opcode of instruction register.
- funct_i      input   6  funct field of instruction register.
- zero_i       input   1  ALU zero flag.
- mem_ready_i  input   1  memory access complete this cycle.
- mem_req_o    output  1  memory access request.
- mem_we_o     output  1  memory write, valid with mem_req_o.
- iord_o       output  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write_o   output  1  load instruction register.
- pc_write_o   output  1  load PC.
- pc_src_o     output  2  PC source: 00 = ALU (PC+4), 01 = ALUOut (branch target), 10 = jump target, 11 = rs (jr).
- reg_write_o  output  1  register file write.
- reg_dst_o    output  2  write register: 00 = rt, 01 = rd, 10 = $31.
- mem_to_reg_o output  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC.
- alu_src_a_o  output  1  ALU A: 0 = PC, 1 = rs.
- alu_src_b_o  output  2  ALU B: 00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op_o     output  3  000 = add, 001 = sub (beq), 010 = funct-decoded (R-type), 100 = slt (slti).
- state_o      output  4  current state code.
- instr_done_o output  1  one-cycle pulse in the final cycle of each instruction.
- illegal_o    output  1  one-cycle pulse on an undecodable opcode.

Function
REQ-003 Opcodes SHALL be decoded as follows:
- R-type 000000
- beq 000100
- addi 001000
- slti 001010
- lw 100011
- sw 101011
- j 000010
- jal 000011
- jr = R-type with funct 001000
REQ-004 State codes SHALL be:
- FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7
- BRANCH 8, JUMP 9, JR 10, I_EXEC 11, I_WB 12
- Codes 13-15 are unused; entering an unused code SHALL return the block to FETCH on the next edge.
REQ-005 FETCH SHALL drive mem_req_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=000, pc_src_o=00.
- ir_write_o and pc_write_o SHALL be 1 only in the cycle where mem_ready_i=1.
- The block SHALL stay in FETCH until mem_ready_i=1, then go to DECODE.
REQ-006 DECODE SHALL drive alu_src_a_o=0, alu_src_b_o=11, alu_op_o=000 (branch target precompute), then transition by opcode:
- lw/sw -> MEM_ADDR
- jr -> JR
- other R-type -> R_EXEC
- beq -> BRANCH
- j/jal -> JUMP
- addi/slti -> I_EXEC
- anything else -> FETCH, with illegal_o=1 and instr_done_o=1 this cycle.
REQ-007 MEM_ADDR SHALL drive alu_src_a_o=1, alu_src_b_o=10, alu_op_o=000, then go to MEM_RD (lw) or MEM_WR (sw).
REQ-008 MEM_RD SHALL drive mem_req_o=1, iord_o=1, mem_we_o=0, hold until mem_ready_i=1, then go to MEM_WB.
REQ-009 MEM_WB SHALL drive reg_write_o=1, reg_dst_o=00, mem_to_reg_o=01, instr_done_o=1, then go to FETCH.
REQ-010 MEM_WR SHALL drive mem_req_o=1, mem_we_o=1, iord_o=1, hold until mem_ready_i=1; instr_done_o=1 in the ready cycle; then go to FETCH.
REQ-011 R_EXEC SHALL drive alu_src_a_o=1, alu_src_b_o=00, alu_op_o=010, then go to R_WB.
REQ-012 R_WB SHALL drive reg_write_o=1, reg_dst_o=01, mem_to_reg_o=00, instr_done_o=1, then go to FETCH.
REQ-013 BRANCH SHALL drive alu_src_a_o=1, alu_src_b_o=00, alu_op_o=001, pc_src_o=01, pc_write_o=zero_i, instr_done_o=1, then go to FETCH.
REQ-014 JUMP SHALL drive pc_write_o=1, pc_src_o=10, instr_done_o=1, then go to FETCH.
- For jal it SHALL also drive reg_write_o=1, reg_dst_o=10, mem_to_reg_o=10 (PC already incremented).
REQ-015 JR SHALL drive pc_write_o=1, pc_src_o=11, reg_write_o=0, instr_done_o=1, then go to FETCH.
REQ-016 I_EXEC SHALL drive alu_src_a_o=1, alu_src_b_o=10, alu_op_o=000 (addi) or 100 (slti), then go to I_WB.
REQ-017 I_WB SHALL drive reg_write_o=1, reg_dst_o=00, mem_to_reg_o=00, instr_done_o=1, then go to FETCH.
REQ-018 Every output not named for a state SHALL be 0 in that state; outputs SHALL be combinational from state, mem_ready_i, zero_i, instr_op_i and funct_i.
REQ-019 Zero-wait latencies (mem_ready_i=1) SHALL be:
- lw 5 cycles
- sw, R-type, addi, slti 4 cycles
- beq, j, jal, jr 3 cycles
- each wait cycle adds one cycle.
REQ-020 The memory handshake SHALL hold mem_req_o, mem_we_o and iord_o stable until the cycle in which mem_ready_i=1; mem_ready_i SHALL be ignored in non-memory states.

Reset
REQ-021 While rst_i=1, every output SHALL be 0 in that same cycle (combinationally gated); state_o SHALL be 0 (FETCH) after the edge.
REQ-022 Reset asserted mid-instruction, including during a memory wait, SHALL abandon the instruction with no write strobe after assertion.

Verification
REQ-023 Reset, then add (op 000000, funct 100000) with mem_ready_i=1 -> state_o sequence 0,1,6,7; in state 7 reg_write_o=1, reg_dst_o=01; instr_done_o in cycle 4.
REQ-024 lw with mem_ready_i=0 for 3 cycles in MEM_RD -> mem_req_o=1, iord_o=1, mem_we_o=0 held 4 cycles; total 8 cycles; MEM_WB mem_to_reg_o=01.
REQ-025 beq with zero_i=1, then with zero_i=0 -> BRANCH pc_src_o=01, pc_write_o=1 then 0; 3 cycles each.
REQ-026 jal -> JUMP: pc_write_o=1, pc_src_o=10, reg_write_o=1, reg_dst_o=10, mem_to_reg_o=10; jr (funct 001000) -> state 10, pc_src_o=11, reg_write_o=0.
REQ-027 Opcode 111111 -> illegal_o=1 and instr_done_o=1 for one cycle in DECODE, next state 0, no reg/mem/pc write strobes.
REQ-028 rst_i=1 during a MEM_WR wait -> mem_req_o=0 and mem_we_o=0 the same cycle; state_o=0 after the edge; no memory write completes.
